// File: rtl/aer_pkg.sv
// Shared AER word format for the transmit encoder and the receive-side decoder.
package aer_pkg;
   localparam int AER_CH_W   = 4;
   localparam int AER_TS_W   = 20;
   localparam int AER_WORD_W = 24;

   typedef struct packed {
      logic [AER_CH_W-1:0] ch;
      logic [AER_TS_W-1:0] ts;
   } aer_word_t;
endpackage

// File: rtl/aer_spike_encoder_if.sv
// AER output stream: one 24-bit word per valid/ready transfer.
interface aer_spike_encoder_if;
   import aer_pkg::*;

   aer_word_t aer_out;
   logic      aer_valid;
   logic      aer_ready;

   modport master (output aer_out, output aer_valid, input aer_ready);
   modport slave  (input aer_out, input aer_valid, output aer_ready);
endinterface

// File: rtl/aer_fifo.sv
// Synchronous FIFO for AER words. Full/empty are registered; the head word is
// presented combinationally and reads as zero while empty.
module aer_fifo
   import aer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      wr_en_i,
   input  aer_word_t wr_data_i,
   input  logic      rd_en_i,
   output aer_word_t rd_data_o,
   output logic      full_o,
   output logic      empty_o
);
   localparam int AW = $clog2(DEPTH);

   aer_word_t     mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          push, pop;

   assign push = wr_en_i && !full_q;
   assign pop  = rd_en_i && !empty_q;

   // Occupancy after this edge; flags are derived from it and registered.
   always_comb begin
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   // Pointers, occupancy and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (AW+1)'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
   assign full_o    = full_q;
   assign empty_o   = empty_q;
endmodule

// File: rtl/aer_spike_encoder.sv
// Transmit-side AER encoder: captures per-channel spike pulses with a 20-bit
// timestamp, merges repeats on still-pending channels, arbitrates round-robin
// into the output FIFO. Optional AER_DROP_CNT_EN adds the saturating
// drop_count port and counter.
module aer_spike_encoder
   import aer_pkg::*;
#(
   parameter int NUM_CH     = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          spike_in,
   aer_spike_encoder_if.master        aer,
   output logic                       drop_pulse
`ifdef AER_DROP_CNT_EN
   ,
   output logic [15:0]                drop_count
`endif
);
   logic [AER_TS_W-1:0]              ts_cnt_q, ts_cnt_d;
   logic [NUM_CH-1:0]                pend_q, pend_d;
   logic [NUM_CH-1:0][AER_TS_W-1:0]  ts_lat_q, ts_lat_d;
   logic [AER_CH_W-1:0]              rr_q, rr_d;
   logic [AER_CH_W-1:0]              cand, gnt_idx;
   logic                             gnt_vld;
   logic [NUM_CH-1:0]                drop_vec;
   logic                             drop_pulse_q;
   logic                             fifo_full, fifo_empty;
   aer_word_t                        wr_word;

   // Round-robin pick: scan downward so the lowest offset from rr_q wins.
   // Grant only uses the registered full flag (no write-through on pop).
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = rr_q;
      cand    = '0;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         cand = rr_q + AER_CH_W'(k);
         if (pend_q[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      if (fifo_full) gnt_vld = 1'b0;
   end

   // Capture and merge. The granted channel is freed first, so a spike there
   // in the same cycle is a fresh event rather than a drop.
   always_comb begin
      pend_d   = pend_q;
      ts_lat_d = ts_lat_q;
      drop_vec = '0;
      if (gnt_vld) pend_d[gnt_idx] = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (spike_in[i]) begin
            if (pend_d[i]) begin
               drop_vec[i] = 1'b1;
            end else begin
               pend_d[i]   = 1'b1;
               ts_lat_d[i] = ts_cnt_q;
            end
         end
      end
   end

   assign ts_cnt_d = ts_cnt_q + 1'b1;
   assign rr_d     = gnt_vld ? gnt_idx + 1'b1 : rr_q;
   assign wr_word  = '{ch: gnt_idx, ts: ts_lat_q[gnt_idx]};

   // Timestamp, pending state, arbiter pointer and drop pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt_q     <= '0;
         pend_q       <= '0;
         ts_lat_q     <= '0;
         rr_q         <= '0;
         drop_pulse_q <= 1'b0;
      end else begin
         ts_cnt_q     <= ts_cnt_d;
         pend_q       <= pend_d;
         ts_lat_q     <= ts_lat_d;
         rr_q         <= rr_d;
         drop_pulse_q <= |drop_vec;
      end
   end

   assign drop_pulse = drop_pulse_q;

`ifdef AER_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [16:0] drop_sum;

   assign drop_sum   = {1'b0, drop_cnt_q} + 17'($countones(drop_vec));
   assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   // Saturating count of merged spikes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`endif

   aer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (gnt_vld),
      .wr_data_i (wr_word),
      .rd_en_i   (aer.aer_ready),
      .rd_data_o (aer.aer_out),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign aer.aer_valid = !fifo_empty;
endmodule

// File: tb/tb_aer_spike_encoder.sv
// Self-checking bench for aer_spike_encoder: directed scenarios plus a
// randomized run against an event-level reference model.
module tb_aer_spike_encoder;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] spike_in = '0;
   logic        drop_pulse;
`ifdef AER_DROP_CNT_EN
   logic [15:0] drop_count;
`endif

   aer_spike_encoder_if bus ();

   aer_spike_encoder #(.NUM_CH(16), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spike_in   (spike_in),
      .aer        (bus),
      .drop_pulse (drop_pulse)
`ifdef AER_DROP_CNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit   [15:0] m_pend;
   logic [19:0] m_tslat [16];
   int          m_rr;
   logic [23:0] m_q [$];
   logic [19:0] m_ts;
   bit          m_dp;
   int          m_dc;

   function automatic void model_reset();
      m_pend = '0;
      for (int c = 0; c < 16; c++) m_tslat[c] = '0;
      m_rr = 0;
      m_q.delete();
      m_ts = '0;
      m_dp = 1'b0;
      m_dc = 0;
   endfunction

   // One clock edge of the encoder, described at event level.
   function automatic void model_edge(input logic [15:0] s, input logic r);
      bit full = (m_q.size() == DEPTH);
      bit pop  = (m_q.size() != 0) && r;
      int g = -1;
      int nd = 0;
      logic [3:0] gch;
      if (!full)
         for (int k = 0; k < 16; k++) begin
            int c = (m_rr + k) % 16;
            if (g < 0 && m_pend[c]) g = c;
         end
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
         gch = g[3:0];
         m_q.push_back({gch, m_tslat[g]});
         m_pend[g] = 1'b0;
         m_rr = (g + 1) % 16;
      end
      for (int c = 0; c < 16; c++)
         if (s[c]) begin
            if (m_pend[c]) nd++;
            else begin
               m_pend[c]  = 1'b1;
               m_tslat[c] = m_ts;
            end
         end
      m_dp = (nd > 0);
      m_dc = (m_dc + nd > 65535) ? 65535 : m_dc + nd;
      m_ts = m_ts + 20'd1;
   endfunction

   task automatic tick(input logic [15:0] s, input logic r);
      spike_in = s;
      bus.aer_ready = r;
      @(posedge clk);
      model_edge(s, r);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      spike_in = '0;
      bus.aer_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_ts(input logic [19:0] t, input logic r);
      int guard = 0;
      while (m_ts != t && guard < 300) begin
         tick('0, r);
         guard++;
      end
      n_cmp++;
      if (m_ts != t) begin
         n_err++;
         $display("FAIL wait_ts timeout: got ts %0h, required %0h", m_ts, t);
      end
   endtask

   task automatic test_reset();
      logic [23:0] w;
      rst_n = 1'b0;
      bus.aer_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      w = bus.aer_out;
      n_cmp++;
      if (bus.aer_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b required 0", bus.aer_valid); end
      n_cmp++;
      if (w !== 24'h0) begin n_err++; $display("FAIL reset_out got %h required 000000", w); end
      n_cmp++;
      if (drop_pulse !== 1'b0) begin n_err++; $display("FAIL reset_drop_pulse got %b required 0", drop_pulse); end
`ifdef AER_DROP_CNT_EN
      n_cmp++;
      if (drop_count !== 16'h0) begin n_err++; $display("FAIL reset_drop_count got %h required 0", drop_count); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [23:0] w;
      do_reset();
      wait_ts(20'd5, 1'b0);
      tick(16'h0008, 1'b0);
      n_cmp++;
      if (bus.aer_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b required 0", bus.aer_valid); end
      tick('0, 1'b0);
      w = bus.aer_out;
      n_cmp++;
      if (bus.aer_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b required 1", bus.aer_valid); end
      n_cmp++;
      if (w !== 24'h300005) begin n_err++; $display("FAIL single_word got %h required 300005", w); end
      n_cmp++;
      if (drop_pulse !== 1'b0) begin n_err++; $display("FAIL single_drop got %b required 0", drop_pulse); end
      tick('0, 1'b1);
      n_cmp++;
      if (bus.aer_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got %b required 0", bus.aer_valid); end
   endtask

   task automatic test_simultaneous();
      logic [23:0] got [$];
      logic [23:0] exp_w;
      do_reset();
      wait_ts(20'h10, 1'b1);
      tick(16'hFFFF, 1'b1);
      for (int i = 0; i < 30; i++) begin
         tick('0, 1'b1);
         if (bus.aer_valid === 1'b1) got.push_back(bus.aer_out);
      end
      n_cmp++;
      if (got.size() != 16) begin n_err++; $display("FAIL simul_count got %0d required 16", got.size()); end
      for (int i = 0; i < got.size() && i < 16; i++) begin
         exp_w = {i[3:0], 20'h00010};
         n_cmp++;
         if (got[i] !== exp_w) begin n_err++; $display("FAIL simul_word[%0d] got %h required %h", i, got[i], exp_w); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] mask = '0;
      logic [19:0] ts0;
      logic [23:0] held, exp_w;
      logic [23:0] got [$];
      int idx = 0;
      bit dropped = 1'b0;
      do_reset();
      while ($countones(mask) < 12) mask[$urandom_range(0, 15)] = 1'b1;
      tick('0, 1'b0);
      ts0 = m_ts;
      tick(mask, 1'b0);
      tick('0, 1'b0);
      held = bus.aer_out;
      for (int i = 0; i < 14; i++) begin
         tick('0, 1'b0);
         n_cmp++;
         if (bus.aer_valid !== 1'b1 || bus.aer_out !== held) begin
            n_err++;
            $display("FAIL bp_stable cyc=%0d got v=%b %h required v=1 %h", i, bus.aer_valid, bus.aer_out, held);
         end
      end
      for (int i = 0; i < 30; i++) begin
         bus.aer_ready = 1'b1;
         if (bus.aer_valid === 1'b1) got.push_back(bus.aer_out);
         tick('0, 1'b1);
         if (drop_pulse === 1'b1) dropped = 1'b1;
      end
      n_cmp++;
      if (got.size() != 12) begin n_err++; $display("FAIL bp_count got %0d required 12", got.size()); end
      n_cmp++;
      if (dropped) begin n_err++; $display("FAIL bp_drop got 1 required 0"); end
      for (int c = 0; c < 16; c++)
         if (mask[c]) begin
            exp_w = {c[3:0], ts0};
            n_cmp++;
            if (idx >= got.size() || got[idx] !== exp_w) begin
               n_err++;
               $display("FAIL bp_word[%0d] got %h required %h", idx, (idx < got.size()) ? got[idx] : 24'hx, exp_w);
            end
            idx++;
         end
   endtask

   task automatic test_merge();
      logic [23:0] got [$];
      int n2 = 0;
      do_reset();
      tick(16'h07F8, 1'b0);
      wait_ts(20'd100, 1'b0);
      tick(16'h0004, 1'b0);
      n_cmp++;
      if (drop_pulse !== 1'b0) begin n_err++; $display("FAIL merge_first got %b required 0", drop_pulse); end
      tick(16'h0004, 1'b0);
      n_cmp++;
      if (drop_pulse !== 1'b1) begin n_err++; $display("FAIL merge_pulse got %b required 1", drop_pulse); end
      tick('0, 1'b0);
      n_cmp++;
      if (drop_pulse !== 1'b0) begin n_err++; $display("FAIL merge_pulse_end got %b required 0", drop_pulse); end
`ifdef AER_DROP_CNT_EN
      n_cmp++;
      if (drop_count !== 16'd1) begin n_err++; $display("FAIL merge_count got %0d required 1", drop_count); end
`endif
      for (int i = 0; i < 30; i++) begin
         if (bus.aer_valid === 1'b1) got.push_back(bus.aer_out);
         tick('0, 1'b1);
      end
      n_cmp++;
      if (got.size() != 9) begin n_err++; $display("FAIL merge_total got %0d required 9", got.size()); end
      foreach (got[i])
         if (got[i][23:20] == 4'd2) begin
            n2++;
            n_cmp++;
            if (got[i] !== 24'h200064) begin n_err++; $display("FAIL merge_word got %h required 200064", got[i]); end
         end
      n_cmp++;
      if (n2 != 1) begin n_err++; $display("FAIL merge_ch2_words got %0d required 1", n2); end
   endtask

   task automatic test_reset_mid();
      logic [23:0] w;
      do_reset();
      tick(16'h001F, 1'b0);
      repeat (6) tick('0, 1'b0);
      n_cmp++;
      if (bus.aer_valid !== 1'b1) begin n_err++; $display("FAIL rmid_queued got %b required 1", bus.aer_valid); end
      rst_n = 1'b0;
      model_reset();
      #1;
      w = bus.aer_out;
      n_cmp++;
      if (bus.aer_valid !== 1'b0 || w !== 24'h0) begin
         n_err++;
         $display("FAIL rmid_async got v=%b %h required v=0 000000", bus.aer_valid, w);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick('0, 1'b1);
         n_cmp++;
         if (bus.aer_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale cyc=%0d got %b required 0", i, bus.aer_valid); end
      end
   endtask

   task automatic test_random();
      logic [15:0] s;
      logic        r;
      logic [23:0] exp_w, w;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         s = 16'($urandom & $urandom & $urandom);
         if (((cyc / 60) % 2) == 1) r = ($urandom_range(0, 3) != 0);
         else                       r = ($urandom_range(0, 4) == 0);
         tick(s, r);
         exp_w = (m_q.size() != 0) ? m_q[0] : 24'h0;
         w = bus.aer_out;
         n_cmp++;
         if (bus.aer_valid !== (m_q.size() != 0) || w !== exp_w) begin
            n_err++;
            $display("FAIL rnd_out cyc=%0d got v=%b %h required v=%b %h", cyc, bus.aer_valid, w, m_q.size() != 0, exp_w);
         end
         n_cmp++;
         if (drop_pulse !== m_dp) begin
            n_err++;
            $display("FAIL rnd_drop cyc=%0d got %b required %b", cyc, drop_pulse, m_dp);
         end
`ifdef AER_DROP_CNT_EN
         n_cmp++;
         if (drop_count !== 16'(m_dc)) begin
            n_err++;
            $display("FAIL rnd_drop_count cyc=%0d got %0d required %0d", cyc, drop_count, m_dc);
         end
`endif
      end
   endtask

   initial begin
      bus.aer_ready = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_merge();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
